pch_pwrseq_model: RTL and testbench
===================================

# pch_pwrseq_model

Parametrised, synthesizable successor to the fixed-delay PCH/BMC sideband emulator in the main CPLD wrapper simulation shim. It runs the aux-rail enable, waits for aux power-good and then for SLP_S3#, and releases NUM_STAGES sideband outputs (e.g. RSMRST#, SRST_BMC#, PCH_PWROK, SYS_PWROK) one at a time with per-stage delays. It adds behaviour the fixed emulator lacks: reverse-order power-down on SLP_S3# de-assertion, an aux power-good timeout, detection of power-good loss, and a sticky fault with explicit clear. It sits in bench/emulation top levels in place of the real PCH, driving the main wrapper's RSMRST/PWROK inputs.

## Interface
- NUM_STAGES, 4, number of sequenced outputs (1..8)
- DLY_W, 16, width of every delay/timeout counter
- AUX_DLY, 2, cycles from leaving IDLE to oAuxEn assertion
- STAGE_DLY, {NUM_STAGES{16'd1}}, packed NUM_STAGES*DLY_W vector; stage i delay at [i*DLY_W +: DLY_W]
- DN_DLY, 2, cycles between successive de-assertions on power-down
- PG_TIMEOUT, 8, cycles allowed for iAuxPgood after oAuxEn rises
- Delay value 0 is treated as 1.

Ports:
- iClk_2M  in  1  clock; all logic on rising edge
- iRst  in  1  synchronous, active-high reset
- iAuxPgood  in  1  aux rail power-good; synchronous to iClk_2M, no internal synchroniser
- iSlpS3_n  in  1  SLP_S3#; synchronous to iClk_2M
- iClrFault  in  1  level, sampled only in FAULT
- oAuxEn  out  1  aux rail enable
- oStage  out  NUM_STAGES  sequenced sideband outputs, active high
- oDone  out  1  all stages asserted
- oFault  out  1  sticky fault
- oFaultCode  out  2  01 = power-good timeout, 10 = power-good lost, 00 = none
- oState  out  3  current FSM state encoding

## Operation
- States (oState): IDLE=0, AUX_DLY=1, WAIT_PG=2, WAIT_S3=3, SEQ_UP=4, ON=5, SEQ_DN=6, FAULT=7.
- Reset: state IDLE; oAuxEn, oStage, oDone, oFault, oFaultCode all 0; counters and stage index 0. iRst overrides every other input on any cycle.
- IDLE -> AUX_DLY on the next edge, unconditionally.
- AUX_DLY: count AUX_DLY edges; on the last edge set oAuxEn=1 and go to WAIT_PG.
- WAIT_PG: iAuxPgood=1 -> WAIT_S3. If iAuxPgood has not been seen high by the PG_TIMEOUT-th edge after entry, go to FAULT with code 01.
- WAIT_S3: iSlpS3_n=1 -> SEQ_UP with idx=0 and the counter loaded from STAGE_DLY[0].
- SEQ_UP: when the counter expires, set oStage[idx]=1. If idx is the last stage, set oDone=1 and go to ON. Otherwise increment idx and load STAGE_DLY[idx].
- ON or SEQ_UP with iSlpS3_n=0 -> SEQ_DN; oDone cleared on that edge. Stages are de-asserted from the highest asserted index downward, one every DN_DLY edges. After oStage[0] drops, go to WAIT_S3.
- SEQ_DN always runs to completion. iSlpS3_n returning high is ignored until WAIT_S3.
- In WAIT_S3, SEQ_UP, ON and SEQ_DN, iAuxPgood=0 -> FAULT with code 10.
- Entering FAULT: on the same edge oStage=0, oDone=0, oAuxEn=0, oFault=1 and oFaultCode is set.
- Priority: iRst > power-good loss/timeout > iSlpS3_n change.
- FAULT: held until iClrFault=1. Then go to IDLE and clear oFault/oFaultCode; the aux sequence restarts.

## Timing
- All outputs are registered. "Edge n samples X" means outputs update at edge n.
- Edge 1 is the first edge with iRst=0. Then AUX_DLY is entered at edge 1 and oAuxEn rises at edge 1+AUX_DLY.
- If edge n samples iSlpS3_n=1 in WAIT_S3:
  - oStage[0] rises at n+STAGE_DLY[0];
  - oStage[i] rises STAGE_DLY[i] edges after oStage[i-1];
  - oDone rises together with the last stage.
- If edge n samples iSlpS3_n=0 in ON/SEQ_UP: first de-assertion at n+DN_DLY, then one every DN_DLY edges. WAIT_S3 is entered on the edge the last stage drops.
- A power-good fault becomes visible on the sampling edge; there is no extra latency.
- Counter arithmetic is unsigned, DLY_W bits. Delays and PG_TIMEOUT must be below 2^DLY_W; counters never wrap.

## Test plan
Parameters for all tests: NUM_STAGES=4, STAGE_DLY={4,3,2,1} (stage0=1), AUX_DLY=2, DN_DLY=2, PG_TIMEOUT=8.
- Normal power-up: release reset, iAuxPgood=1 sampled at edge 5, iSlpS3_n=1 sampled at edge 10 -> oAuxEn rises at edge 3; oState=3 at edge 5; oStage[0..3] rise at edges 11/13/16/20; oDone=1 at 20.
- Power-down: from ON, iSlpS3_n=0 sampled at edge 30 -> oDone=0 at 30; oStage[3..0] fall at edges 32/34/36/38; oState=3 at 38.
- Power-good timeout: iAuxPgood held 0 -> oFault=1, oFaultCode=01, oAuxEn=0, oState=7 at edge 11. iClrFault sampled at edge 20 -> oState=0 at 20; oAuxEn rises at edge 23.
- Power-good loss in ON: iAuxPgood=0 sampled at edge k -> all oStage=0, oDone=0, oAuxEn=0, oFaultCode=10 at edge k.
- Abort mid-up plus glitch: oStage[1:0] up by edge 13; iSlpS3_n=0 at 14, 1 again at 15 -> oStage[1] falls at 16, oStage[0] at 18; oStage[2] never rises; WAIT_S3 at 18; oStage[0] rises at 20.
- Reset mid-sequence: iRst=1 sampled during SEQ_UP -> every output 0 and oState=0 on that edge.

Source files
------------

// File: rtl/pch_pwrseq_model.sv
// PCH/BMC sideband power-sequence emulator: aux rail bring-up, staged sideband
// release on SLP_S3#, reverse-order power-down and sticky power-good faults.
module pch_pwrseq_model #(
  parameter int                          NUM_STAGES = 4,
  parameter int                          DLY_W      = 16,
  parameter int                          AUX_DLY    = 2,
  parameter logic [NUM_STAGES*DLY_W-1:0] STAGE_DLY  = {NUM_STAGES{16'd1}},
  parameter int                          DN_DLY     = 2,
  parameter int                          PG_TIMEOUT = 8
) (
  input  logic                  iClk_2M,
  input  logic                  iRst,
  input  logic                  iAuxPgood,
  input  logic                  iSlpS3_n,
  input  logic                  iClrFault,
  output logic                  oAuxEn,
  output logic [NUM_STAGES-1:0] oStage,
  output logic                  oDone,
  output logic                  oFault,
  output logic [1:0]            oFaultCode,
  output logic [2:0]            oState
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [DLY_W-1:0] ONE = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AUX_DLY = 3'd1,
    ST_WAIT_PG = 3'd2,
    ST_WAIT_S3 = 3'd3,
    ST_SEQ_UP  = 3'd4,
    ST_ON      = 3'd5,
    ST_SEQ_DN  = 3'd6,
    ST_FAULT   = 3'd7
  } st_t;

  // A zero delay behaves as a one-cycle delay.
  function automatic logic [DLY_W-1:0] eff_dly(input logic [DLY_W-1:0] d);
    return (d == {DLY_W{1'b0}}) ? ONE : d;
  endfunction

  function automatic logic [DLY_W-1:0] stage_last(input logic [IDX_W-1:0] i);
    logic [DLY_W-1:0] d;
    d = STAGE_DLY[int'(i)*DLY_W +: DLY_W];
    return eff_dly(d) - ONE;
  endfunction

  localparam logic [DLY_W-1:0] AUX_LAST = eff_dly(DLY_W'(AUX_DLY)) - ONE;
  localparam logic [DLY_W-1:0] PG_LAST  = eff_dly(DLY_W'(PG_TIMEOUT)) - ONE;
  localparam logic [DLY_W-1:0] DN_LAST  = eff_dly(DLY_W'(DN_DLY)) - ONE;

  st_t                   state_r, state_nx_s;
  logic [DLY_W-1:0]      cnt_r, cnt_nx_s;
  logic [IDX_W-1:0]      idx_r, idx_nx_s;
  logic                  aux_en_nx_s, done_nx_s, fault_nx_s, pg_lost_s;
  logic [NUM_STAGES-1:0] stage_nx_s;
  logic [1:0]            code_nx_s;

  // Next-state and next-output logic; power-good loss outranks SLP_S3# changes.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    idx_nx_s    = idx_r;
    aux_en_nx_s = oAuxEn;
    stage_nx_s  = oStage;
    done_nx_s   = oDone;
    fault_nx_s  = oFault;
    code_nx_s   = oFaultCode;
    pg_lost_s   = !iAuxPgood && ((state_r == ST_WAIT_S3) || (state_r == ST_SEQ_UP) ||
                                 (state_r == ST_ON) || (state_r == ST_SEQ_DN));
    if (pg_lost_s) begin
      state_nx_s  = ST_FAULT;
      aux_en_nx_s = 1'b0;
      stage_nx_s  = '0;
      done_nx_s   = 1'b0;
      fault_nx_s  = 1'b1;
      code_nx_s   = 2'b10;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_AUX_DLY;
          cnt_nx_s   = '0;
        end
        ST_AUX_DLY: begin
          if (cnt_r == AUX_LAST) begin
            aux_en_nx_s = 1'b1;
            state_nx_s  = ST_WAIT_PG;
            cnt_nx_s    = '0;
          end else begin
            cnt_nx_s = cnt_r + ONE;
          end
        end
        ST_WAIT_PG: begin
          if (iAuxPgood) begin
            state_nx_s = ST_WAIT_S3;
            cnt_nx_s   = '0;
          end else if (cnt_r == PG_LAST) begin
            state_nx_s  = ST_FAULT;
            aux_en_nx_s = 1'b0;
            fault_nx_s  = 1'b1;
            code_nx_s   = 2'b01;
          end else begin
            cnt_nx_s = cnt_r + ONE;
          end
        end
        ST_WAIT_S3: begin
          if (iSlpS3_n) begin
            state_nx_s = ST_SEQ_UP;
            idx_nx_s   = '0;
            cnt_nx_s   = '0;
          end else begin
            cnt_nx_s = '0;
          end
        end
        ST_SEQ_UP: begin
          // idx is the stage still pending, so idx-1 is the highest one asserted.
          if (!iSlpS3_n) begin
            done_nx_s = 1'b0;
            cnt_nx_s  = '0;
            if (idx_r == '0) begin
              state_nx_s = ST_WAIT_S3;
            end else begin
              state_nx_s = ST_SEQ_DN;
              idx_nx_s   = idx_r - 1'b1;
            end
          end else if (cnt_r == stage_last(idx_r)) begin
            stage_nx_s[idx_r] = 1'b1;
            cnt_nx_s          = '0;
            if (idx_r == LAST_IDX) begin
              done_nx_s  = 1'b1;
              state_nx_s = ST_ON;
            end else begin
              idx_nx_s = idx_r + 1'b1;
            end
          end else begin
            cnt_nx_s = cnt_r + ONE;
          end
        end
        ST_ON: begin
          if (!iSlpS3_n) begin
            done_nx_s  = 1'b0;
            state_nx_s = ST_SEQ_DN;
            idx_nx_s   = LAST_IDX;
            cnt_nx_s   = '0;
          end else begin
            cnt_nx_s = '0;
          end
        end
        ST_SEQ_DN: begin
          if (cnt_r == DN_LAST) begin
            stage_nx_s[idx_r] = 1'b0;
            cnt_nx_s          = '0;
            if (idx_r == '0) begin
              state_nx_s = ST_WAIT_S3;
            end else begin
              idx_nx_s = idx_r - 1'b1;
            end
          end else begin
            cnt_nx_s = cnt_r + ONE;
          end
        end
        ST_FAULT: begin
          if (iClrFault) begin
            state_nx_s = ST_IDLE;
            fault_nx_s = 1'b0;
            code_nx_s  = 2'b00;
            cnt_nx_s   = '0;
            idx_nx_s   = '0;
          end else begin
            cnt_nx_s = '0;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge iClk_2M) begin
    if (iRst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      idx_r      <= '0;
      oAuxEn     <= 1'b0;
      oStage     <= '0;
      oDone      <= 1'b0;
      oFault     <= 1'b0;
      oFaultCode <= 2'b00;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      idx_r      <= idx_nx_s;
      oAuxEn     <= aux_en_nx_s;
      oStage     <= stage_nx_s;
      oDone      <= done_nx_s;
      oFault     <= fault_nx_s;
      oFaultCode <= code_nx_s;
    end
  end

  assign oState = state_r;

endmodule

// File: tb/tb_pch_pwrseq_model.sv
// Self-checking bench for pch_pwrseq_model: directed edge-timing scenarios plus
// randomized inputs compared every cycle against an event-deadline reference model.
module tb_pch_pwrseq_model;

  localparam int NS = 4, AUXD = 2, DND = 2, PGTO = 8;

  logic       clk = 1'b0;
  logic       rst, pg, s3, clr;
  logic       aux_en, done, fault;
  logic [3:0] stage;
  logic [1:0] code;
  logic [2:0] st;

  int n_tests = 0, n_fail = 0, e = 0;

  // Reference model: phase number, count of asserted stages, absolute deadline edge.
  int m_ph, m_n, m_dl, m_aux, m_done, m_fault, m_code;
  int m_dly [0:3] = '{1, 2, 3, 4};

  // Directed expectations: scenario, edge, signal (0 aux,1 stage,2 done,3 fault,4 code,5 state), value.
  localparam int NT = 56;
  int tbl [0:NT-1][0:3] = '{
    '{0,2,0,0}, '{0,3,0,1}, '{0,4,5,2}, '{0,5,5,3}, '{0,10,1,0}, '{0,11,1,1}, '{0,12,1,1},
    '{0,13,1,3}, '{0,15,1,3}, '{0,16,1,7}, '{0,19,1,7}, '{0,19,2,0}, '{0,20,1,15}, '{0,20,2,1},
    '{0,20,5,5}, '{0,30,2,0}, '{0,31,1,15}, '{0,32,1,7}, '{0,34,1,3}, '{0,36,1,1}, '{0,37,5,6},
    '{0,38,1,0}, '{0,38,5,3},
    '{1,10,5,2}, '{1,11,3,1}, '{1,11,4,1}, '{1,11,0,0}, '{1,11,5,7}, '{1,19,5,7}, '{1,20,5,0},
    '{1,20,3,0}, '{1,20,4,0}, '{1,22,0,0}, '{1,23,0,1},
    '{2,24,1,15}, '{2,25,1,0}, '{2,25,2,0}, '{2,25,0,0}, '{2,25,4,2}, '{2,25,5,7}, '{2,25,3,1},
    '{3,13,1,3}, '{3,14,5,6}, '{3,15,1,3}, '{3,16,1,1}, '{3,17,1,1}, '{3,18,1,0}, '{3,18,5,3},
    '{3,19,5,4}, '{3,20,1,1},
    '{4,14,5,4}, '{4,15,5,0}, '{4,15,1,0}, '{4,15,0,0}, '{4,15,2,0}, '{4,16,5,1}
  };

  pch_pwrseq_model #(
    .NUM_STAGES(NS), .DLY_W(16), .AUX_DLY(AUXD),
    .STAGE_DLY({16'd4, 16'd3, 16'd2, 16'd1}), .DN_DLY(DND), .PG_TIMEOUT(PGTO)
  ) dut (
    .iClk_2M(clk), .iRst(rst), .iAuxPgood(pg), .iSlpS3_n(s3), .iClrFault(clr),
    .oAuxEn(aux_en), .oStage(stage), .oDone(done), .oFault(fault),
    .oFaultCode(code), .oState(st)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0d expected %0d", tag, e, got, exp);
    end
  endtask

  task automatic model_edge();
    bit pg_phase;
    if (rst) begin
      m_ph = 0; m_n = 0; m_dl = 0; m_aux = 0; m_done = 0; m_fault = 0; m_code = 0;
    end else begin
      pg_phase = (m_ph >= 3) && (m_ph <= 6);
      if (pg_phase && !pg) begin
        m_ph = 7; m_n = 0; m_done = 0; m_aux = 0; m_fault = 1; m_code = 2;
      end else begin
        case (m_ph)
          0: begin m_ph = 1; m_dl = e + AUXD; end
          1: if (e == m_dl) begin m_aux = 1; m_ph = 2; m_dl = e + PGTO; end
          2: if (pg) m_ph = 3;
             else if (e == m_dl) begin m_ph = 7; m_aux = 0; m_fault = 1; m_code = 1; end
          3: if (s3) begin m_ph = 4; m_dl = e + m_dly[0]; end
          4: if (!s3) begin
               m_done = 0;
               if (m_n == 0) m_ph = 3;
               else begin m_ph = 6; m_dl = e + DND; end
             end else if (e == m_dl) begin
               m_n++;
               if (m_n == NS) begin m_done = 1; m_ph = 5; end
               else m_dl = e + m_dly[m_n];
             end
          5: if (!s3) begin m_done = 0; m_ph = 6; m_dl = e + DND; end
          6: if (e == m_dl) begin
               m_n--;
               if (m_n == 0) m_ph = 3; else m_dl = e + DND;
             end
          7: if (clr) begin m_ph = 0; m_fault = 0; m_code = 0; end
          default: m_ph = 0;
        endcase
      end
    end
  endtask

  function automatic logic [31:0] dut_sig(input int s);
    case (s)
      0: return 32'(aux_en);
      1: return 32'(stage);
      2: return 32'(done);
      3: return 32'(fault);
      4: return 32'(code);
      default: return 32'(st);
    endcase
  endfunction

  // One clock edge: advance model, then compare every output just after the edge.
  task automatic step();
    @(posedge clk);
    e++;
    model_edge();
    #1;
    check("aux_en", 32'(aux_en), 32'(m_aux));
    check("stage", 32'(stage), 32'((1 << m_n) - 1));
    check("done", 32'(done), 32'(m_done));
    check("fault", 32'(fault), 32'(m_fault));
    check("fault_code", 32'(code), 32'(m_code));
    check("state", 32'(st), 32'(m_ph));
  endtask

  task automatic do_reset();
    rst = 1'b1; pg = 1'b0; s3 = 1'b0; clr = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    e = 0;
  endtask

  task automatic drive(input int id, input int ne);
    rst = 1'b0; clr = 1'b0; pg = (ne >= 5); s3 = 1'b0;
    case (id)
      0: s3 = (ne >= 10) && (ne < 30);
      1: begin pg = 1'b0; clr = (ne == 20); end
      2: begin pg = (ne >= 5) && (ne < 25); s3 = (ne >= 10); end
      3: s3 = (ne >= 10) && (ne != 14);
      default: begin s3 = (ne >= 10); rst = (ne == 15); end
    endcase
  endtask

  task automatic run_scn(input int id, input int len);
    do_reset();
    for (int ne = 1; ne <= len; ne++) begin
      drive(id, ne);
      step();
      for (int k = 0; k < NT; k++)
        if (tbl[k][0] == id && tbl[k][1] == e)
          check($sformatf("scn%0d_sig%0d", id, tbl[k][2]), dut_sig(tbl[k][2]), 32'(tbl[k][3]));
    end
  endtask

  initial begin
    rst = 1'b1; pg = 1'b0; s3 = 1'b0; clr = 1'b0;
    run_scn(0, 40);
    run_scn(1, 25);
    run_scn(2, 27);
    run_scn(3, 22);
    run_scn(4, 18);
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (pg) pg = ($urandom_range(59, 0) != 0);
      else    pg = ($urandom_range(2, 0) == 0);
      if ($urandom_range(11, 0) == 0) s3 = ~s3;
      clr = ($urandom_range(4, 0) == 0);
      rst = ($urandom_range(399, 0) == 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
